// File: rtl/hazard_fwd_unit.sv
// Hazard controller for the 5-stage pipeline: operand forwarding selects,
// load-use stall, multi-cycle branch flush and saturating stall/flush counters.
module hazard_fwd_unit #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NSTAGE    = 2,
  parameter int unsigned SEL_W     = $clog2(NSTAGE + 1),
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned FLUSH_LEN = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs,
  input  logic [REG_AW-1:0]        id_rt,
  input  logic [REG_AW-1:0]        ex_rs,
  input  logic [REG_AW-1:0]        ex_rt,
  input  logic [REG_AW-1:0]        ex_dst,
  input  logic                     ex_regwr,
  input  logic                     ex_memrd,
  input  logic [NSTAGE*REG_AW-1:0] fwd_dst,
  input  logic [NSTAGE-1:0]        fwd_regwr,
  input  logic                     branch_taken,
  input  logic                     clr_stats,
  output logic [SEL_W-1:0]         fwd_a,
  output logic [SEL_W-1:0]         fwd_b,
  output logic                     stall,
  output logic                     bubble_ex,
  output logic                     flush,
  output logic [CNT_W-1:0]         stall_count,
  output logic [CNT_W-1:0]         flush_count
);

  localparam int unsigned MAX_LEN = (LOAD_LAT > FLUSH_LEN) ? LOAD_LAT : FLUSH_LEN;
  localparam int unsigned CW      = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          hz;

  // Load-use hazard: ID reads the register a load in EX is about to produce
  assign hz = id_valid & ex_memrd & ex_regwr & (ex_dst != '0) &
              ((ex_dst == id_rs) | (ex_dst == id_rt));

  // Forwarding selects; scan farthest to nearest so the nearest match wins
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (reset) begin
      for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
        if (fwd_regwr[k] && (ex_rs != '0) && (fwd_dst[k*REG_AW +: REG_AW] == ex_rs))
          fwd_a = SEL_W'(k + 1);
        if (fwd_regwr[k] && (ex_rt != '0) && (fwd_dst[k*REG_AW +: REG_AW] == ex_rt))
          fwd_b = SEL_W'(k + 1);
      end
    end
  end

  // Pipeline control outputs; a taken branch overrides any stall
  always_comb begin
    stall     = 1'b0;
    bubble_ex = 1'b0;
    flush     = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (branch_taken) begin
            flush = 1'b1;
          end else if (hz) begin
            stall     = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        STALL: begin
          if (branch_taken) begin
            flush = 1'b1;
          end else begin
            stall     = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        FLUSH:   flush = 1'b1;
        default: ;
      endcase
    end
  end

  // State and remaining-cycle counter for multi-cycle stall/flush
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_taken) begin
            if (FLUSH_LEN > 1) begin
              state <= FLUSH;
              cnt   <= CW'(FLUSH_LEN - 1);
            end
          end else if (hz && (LOAD_LAT > 1)) begin
            state <= STALL;
            cnt   <= CW'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          if (branch_taken) begin
            if (FLUSH_LEN > 1) begin
              state <= FLUSH;
              cnt   <= CW'(FLUSH_LEN - 1);
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= IDLE;
          end
        end
        FLUSH: begin
          if (branch_taken) begin
            if (FLUSH_LEN > 1) cnt   <= CW'(FLUSH_LEN - 1);
            else               state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating statistics; clear wins over increment
  always_ff @(posedge clk) begin
    if (!reset || clr_stats) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: forwarding vector table, hand-written
// control sequences and a randomized run against a cycle-count reference model.
module tb_hazard_fwd_unit;

  localparam int REG_AW = 5;
  localparam int NSTAGE = 2;
  localparam int SEL_W  = 2;
  localparam int LL     = 2;
  localparam int FL     = 3;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     id_valid, ex_regwr, ex_memrd, branch_taken, clr_stats;
  logic [REG_AW-1:0]        id_rs, id_rt, ex_rs, ex_rt, ex_dst;
  logic [NSTAGE*REG_AW-1:0] fwd_dst;
  logic [NSTAGE-1:0]        fwd_regwr;
  logic [SEL_W-1:0]         fwd_a, fwd_b;
  logic                     stall, bubble_ex, flush;
  logic [CNT_W-1:0]         stall_count, flush_count;

  int n_cmp = 0;
  int n_err = 0;

  hazard_fwd_unit #(
    .REG_AW(REG_AW), .NSTAGE(NSTAGE), .SEL_W(SEL_W),
    .LOAD_LAT(LL), .FLUSH_LEN(FL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_regwr(ex_regwr),
    .ex_memrd(ex_memrd), .fwd_dst(fwd_dst), .fwd_regwr(fwd_regwr),
    .branch_taken(branch_taken), .clr_stats(clr_stats),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .bubble_ex(bubble_ex),
    .flush(flush), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int m_sr = 0;  // stall cycles still owed after the current one
  int m_fr = 0;  // flush cycles still owed after the current one
  int m_sc = 0;
  int m_fc = 0;

  function automatic logic hz_f(input logic v, input logic rd, input logic wr,
                                input logic [4:0] d, input logic [4:0] rs, input logic [4:0] rt);
    return v && rd && wr && (d != 0) && (d == rs || d == rt);
  endfunction

  function automatic int fwd_f(input logic rst, input logic [4:0] src,
                               input logic [NSTAGE*REG_AW-1:0] dst, input logic [NSTAGE-1:0] we);
    logic [NSTAGE*REG_AW-1:0] d;
    d = dst;
    if (!rst || src == 0) return 0;
    for (int k = 1; k <= NSTAGE; k++)
      if (we[k-1] && d[(k-1)*REG_AW +: REG_AW] == src) return k;
    return 0;
  endfunction

  function automatic void ctl(input logic rst, input logic br, input logic hzv,
                              input int sr, input int fr,
                              output logic st, output logic fl, output int nsr, output int nfr);
    st = 0; fl = 0; nsr = 0; nfr = 0;
    if (!rst) return;
    if (fr > 0) begin
      fl = 1; nfr = br ? FL - 1 : fr - 1;
    end else if (sr > 0) begin
      if (br) begin fl = 1; nfr = FL - 1; end
      else begin st = 1; nsr = sr - 1; end
    end else if (br) begin
      fl = 1; nfr = FL - 1;
    end else if (hzv) begin
      st = 1; nsr = LL - 1;
    end
  endfunction

  always @(posedge clk) begin : model
    automatic logic st, fl;
    automatic int nsr, nfr;
    ctl(reset, branch_taken, hz_f(id_valid, ex_memrd, ex_regwr, ex_dst, id_rs, id_rt),
        m_sr, m_fr, st, fl, nsr, nfr);
    m_sr <= nsr;
    m_fr <= nfr;
    if (!reset || clr_stats) begin
      m_sc <= 0;
      m_fc <= 0;
    end else begin
      if (st && m_sc < CMAX) m_sc <= m_sc + 1;
      if (fl && m_fc < CMAX) m_fc <= m_fc + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_dst = 0;
    ex_regwr = 0; ex_memrd = 0; fwd_dst = '0; fwd_regwr = '0;
    branch_taken = 0; clr_stats = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    tick();
    reset = 1;
  endtask

  task automatic set_load_use();
    ex_memrd = 1; ex_regwr = 1; ex_dst = 5'd4; id_rs = 5'd4; id_valid = 1;
  endtask

  task automatic cyc(input string nm, input logic st, input logic fl);
    @(negedge clk);
    chk({nm, ".stall"}, stall, st);
    chk({nm, ".bubble_ex"}, bubble_ex, st);
    chk({nm, ".flush"}, flush, fl);
    tick();
  endtask

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [9:0] dst;
    logic [1:0] we;
    int         a;
    int         b;
  } fvec_t;

  fvec_t ftab[8];

  // ---------------- test ----------------
  initial begin
    logic est, efl;
    int   ensr, enfr;

    ftab[0] = '{5'd7,  5'd7, {5'd7,  5'd7},  2'b11, 1, 1};
    ftab[1] = '{5'd7,  5'd7, {5'd7,  5'd7},  2'b10, 2, 2};
    ftab[2] = '{5'd0,  5'd7, {5'd0,  5'd0},  2'b11, 0, 0};
    ftab[3] = '{5'd3,  5'd5, {5'd5,  5'd3},  2'b11, 1, 2};
    ftab[4] = '{5'd3,  5'd5, {5'd5,  5'd3},  2'b00, 0, 0};
    ftab[5] = '{5'd9,  5'd9, {5'd9,  5'd8},  2'b11, 2, 2};
    ftab[6] = '{5'd0,  5'd0, {5'd0,  5'd0},  2'b11, 0, 0};
    ftab[7] = '{5'd31, 5'd4, {5'd31, 5'd31}, 2'b01, 1, 0};

    // Reset state
    reset = 0;
    idle_inputs();
    tick();
    @(negedge clk);
    chk("rst.stall", stall, 0);
    chk("rst.flush", flush, 0);
    chk("rst.stall_count", stall_count, 0);
    chk("rst.flush_count", flush_count, 0);
    tick();
    reset = 1;

    // Forwarding vectors
    for (int i = 0; i < 8; i++) begin
      ex_rs = ftab[i].rs; ex_rt = ftab[i].rt;
      fwd_dst = ftab[i].dst; fwd_regwr = ftab[i].we;
      @(negedge clk);
      chk($sformatf("fwd[%0d].a", i), fwd_a, ftab[i].a);
      chk($sformatf("fwd[%0d].b", i), fwd_b, ftab[i].b);
      tick();
    end

    // Load-use: two stall cycles
    do_reset();
    set_load_use();
    cyc("lu1", 1, 0);
    ex_memrd = 0;
    cyc("lu2", 1, 0);
    cyc("lu3", 0, 0);
    chk("lu.stall_count", stall_count, 2);

    // Branch flush, then re-triggered flush
    do_reset();
    branch_taken = 1;
    cyc("br1", 0, 1);
    branch_taken = 0;
    cyc("br2", 0, 1);
    cyc("br3", 0, 1);
    cyc("br4", 0, 0);
    chk("br.flush_count", flush_count, 3);
    do_reset();
    branch_taken = 1;
    cyc("rb1", 0, 1);
    cyc("rb2", 0, 1);
    branch_taken = 0;
    cyc("rb3", 0, 1);
    cyc("rb4", 0, 1);
    cyc("rb5", 0, 0);
    chk("rb.flush_count", flush_count, 4);

    // Branch aborts a stall
    do_reset();
    set_load_use();
    cyc("bs1", 1, 0);
    ex_memrd = 0;
    branch_taken = 1;
    cyc("bs2", 0, 1);
    branch_taken = 0;
    cyc("bs3", 0, 1);
    cyc("bs4", 0, 1);
    cyc("bs5", 0, 0);
    chk("bs.stall_count", stall_count, 1);
    chk("bs.flush_count", flush_count, 3);

    // Saturation and clear
    do_reset();
    set_load_use();
    for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i), 1, 0);
    chk("sat.stall_count", stall_count, CMAX);
    cyc("sat_hold", 1, 0);
    chk("sat.held", stall_count, CMAX);
    clr_stats = 1;
    tick();
    chk("clr.stall_count", stall_count, 0);
    clr_stats = 0;
    idle_inputs();
    tick(); tick();

    // Reset in the middle of a flush
    do_reset();
    branch_taken = 1;
    cyc("rf1", 0, 1);
    branch_taken = 0;
    reset = 0;
    ex_rs = 5'd7; ex_rt = 5'd7; fwd_dst = {5'd7, 5'd7}; fwd_regwr = 2'b11;
    @(negedge clk);
    chk("rf.stall", stall, 0);
    chk("rf.bubble_ex", bubble_ex, 0);
    chk("rf.flush", flush, 0);
    chk("rf.fwd_a", fwd_a, 0);
    chk("rf.fwd_b", fwd_b, 0);
    tick();
    chk("rf.stall_count", stall_count, 0);
    chk("rf.flush_count", flush_count, 0);
    reset = 1;
    idle_inputs();
    cyc("rf2", 0, 0);
    cyc("rf3", 0, 0);

    // Randomized run against the reference model
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 39) != 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rs        = 5'($urandom_range(0, 3));
      ex_rt        = 5'($urandom_range(0, 3));
      ex_dst       = 5'($urandom_range(0, 3));
      ex_regwr     = 1'($urandom);
      ex_memrd     = 1'($urandom);
      fwd_dst      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_regwr    = 2'($urandom);
      branch_taken = ($urandom_range(0, 5) == 0);
      clr_stats    = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      ctl(reset, branch_taken, hz_f(id_valid, ex_memrd, ex_regwr, ex_dst, id_rs, id_rt),
          m_sr, m_fr, est, efl, ensr, enfr);
      chk($sformatf("rnd%0d.fwd_a", i), fwd_a, fwd_f(reset, ex_rs, fwd_dst, fwd_regwr));
      chk($sformatf("rnd%0d.fwd_b", i), fwd_b, fwd_f(reset, ex_rt, fwd_dst, fwd_regwr));
      chk($sformatf("rnd%0d.stall", i), stall, est);
      chk($sformatf("rnd%0d.bubble_ex", i), bubble_ex, est);
      chk($sformatf("rnd%0d.flush", i), flush, efl);
      chk($sformatf("rnd%0d.stall_count", i), stall_count, m_sc);
      chk($sformatf("rnd%0d.flush_count", i), flush_count, m_fc);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised hazard controller for the 5-stage pipeline. It generates per-operand forwarding selects from NSTAGE write-back sources, detects load-use hazards and stalls for a configurable load latency, and drives a multi-cycle flush after a taken branch. It also keeps saturating stall and flush statistics. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their hold and clear inputs.

Parameters:
REG_AW, 5, register-address width.
NSTAGE, 2, number of forwarding sources; index 1 is the nearest stage (EX/MEM), index NSTAGE the farthest.
SEL_W, $clog2(NSTAGE+1), width of a forwarding select.
LOAD_LAT, 1, stall cycles per load-use hazard; must be ≥1.
FLUSH_LEN, 1, cycles flush is held per taken branch; must be ≥1.
CNT_W, 16, statistics counter width.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset.
id_valid  in  1  ID stage holds a real instruction.
id_rs  in  REG_AW  rs of the ID instruction.
id_rt  in  REG_AW  rt of the ID instruction.
ex_rs  in  REG_AW  rs of the EX instruction.
ex_rt  in  REG_AW  rt of the EX instruction.
ex_dst  in  REG_AW  destination register of the EX instruction.
ex_regwr  in  1  EX instruction writes the register file.
ex_memrd  in  1  EX instruction is a load.
fwd_dst  in  NSTAGE*REG_AW  destination register per source; slice k-1 belongs to source k.
fwd_regwr  in  NSTAGE  register-write enable per source.
branch_taken  in  1  branch resolved taken this cycle.
clr_stats  in  1  synchronous clear of the statistics counters.
fwd_a  out  SEL_W  ALU operand A select; 0 = register file, k = source k.
fwd_b  out  SEL_W  ALU operand B select; same encoding as fwd_a.
stall  out  1  hold PC and IF/ID.
bubble_ex  out  1  load a NOP into ID/EX.
flush  out  1  clear IF/ID and ID/EX.
stall_count  out  CNT_W  cycles with stall=1.
flush_count  out  CNT_W  cycles with flush=1.

Behaviour:
- Reset (reset=0 at an edge): state←IDLE, internal counter←0, stall_count←0, flush_count←0. All combinational outputs are forced to 0 in any cycle where reset=0.
- Forwarding is combinational and independent of the FSM.
  - fwd_a is the lowest k with fwd_regwr[k-1]=1, fwd_dst slice k-1 == ex_rs, and ex_rs≠0. If no k qualifies, fwd_a=0.
  - fwd_b follows the same rule against ex_rt.
  - Register 0 is never forwarded. The nearest source wins when several match.
- Load-use hazard (hz) = id_valid & ex_memrd & ex_regwr & (ex_dst≠0) & (ex_dst==id_rs | ex_dst==id_rt).
- FSM states: IDLE, STALL, FLUSH. Counter cnt has width $clog2(max(LOAD_LAT,FLUSH_LEN))+1.
- IDLE:
  - branch_taken=1: flush=1 this cycle. If FLUSH_LEN>1, go to FLUSH with cnt=FLUSH_LEN-1.
  - else hz=1: stall=1 and bubble_ex=1 this cycle. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1.
  - Otherwise all control outputs are 0.
- STALL:
  - Outputs: stall=1, bubble_ex=1, flush=0. hz is ignored.
  - cnt decrements; on cnt==1 at the edge, go to IDLE.
  - branch_taken=1 aborts the stall: stall=0, bubble_ex=0 and flush=1 this cycle. Next state is FLUSH with cnt=FLUSH_LEN-1, or IDLE if FLUSH_LEN==1.
- FLUSH:
  - Outputs: flush=1, stall=0, bubble_ex=0. hz is ignored, since the instructions are being flushed.
  - cnt decrements; on cnt==1 at the edge, go to IDLE.
  - branch_taken=1 reloads cnt=FLUSH_LEN-1, or goes to IDLE if FLUSH_LEN==1.
- Priority: reset > branch_taken > hazard.
- Statistics:
  - stall_count increments on each edge where stall=1; flush_count increments on each edge where flush=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - clr_stats=1 zeroes both counters and takes priority over incrementing. The FSM is unaffected.
- Reset asserted mid-STALL or mid-FLUSH returns to IDLE at that edge. No residual stall or flush in the following cycle.

Test Plan:
All scenarios use REG_AW=5, NSTAGE=2, LOAD_LAT=2, FLUSH_LEN=3.
1. Forwarding priority: ex_rs=ex_rt=7, fwd_dst={7,7}, fwd_regwr=2'b11 -> fwd_a=fwd_b=1. Then set fwd_regwr=2'b10 -> fwd_a=fwd_b=2. Then set ex_rs=0 with fwd_dst={0,0} -> fwd_a=0.
2. Load-use: ex_memrd=1, ex_regwr=1, ex_dst=4, id_rs=4, id_valid=1 for one cycle, then ex_memrd=0 -> stall=bubble_ex=1 for exactly 2 cycles, then 0; stall_count=2.
3. Branch flush: one-cycle branch_taken pulse in IDLE -> flush=1 for exactly 3 cycles; flush_count=3. A second pulse in the 2nd flush cycle -> flush holds for 3 further cycles (4 total).
4. Branch during stall: start load-use as in scenario 2, then branch_taken=1 in the 2nd stall cycle -> that cycle shows stall=0 and flush=1, followed by 2 more flush cycles; stall_count=1, flush_count=3.
5. Saturation and clear: with CNT_W=4, hold a hazard with repeated loads for 20 cycles -> stall_count=15 and held there. Then clr_stats=1 for one cycle -> stall_count=0 next cycle.
6. Reset mid-FLUSH: reset=0 in the 2nd flush cycle -> all outputs 0 in that cycle and counters 0 after the edge. Release reset with no stimulus -> outputs remain 0.
